// File: rtl/pipelined_carry_chain_adder_if.sv
// pipelined_carry_chain_adder_if
// Bundles the input and output handshakes of the pipelined carry-chain adder.
//   in_valid / in_ready  : input handshake (in_ready driven by the adder)
//   prop, gen, cin       : per-bit propagate, per-bit generate, carry into bit 0
//   out_valid / out_ready: output handshake (out_ready driven by the consumer)
//   product              : registered sum
//   cout                 : carry out of the top bit (only with CCA_COUT_EN)
// modport master : producer/consumer side (testbench or surrounding logic)
// modport slave  : the adder itself
// Optional feature macro: CCA_COUT_EN
interface pipelined_carry_chain_adder_if #(
    parameter int WIDTH = 22
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
`ifdef CCA_COUT_EN
    logic             cout;

    modport master (
        output in_valid, prop, gen, cin, out_ready,
        input  in_ready, out_valid, product, cout
    );
    modport slave (
        input  in_valid, prop, gen, cin, out_ready,
        output in_ready, out_valid, product, cout
    );
`else
    modport master (
        output in_valid, prop, gen, cin, out_ready,
        input  in_ready, out_valid, product
    );
    modport slave (
        input  in_valid, prop, gen, cin, out_ready,
        output in_ready, out_valid, product
    );
`endif
endinterface

// File: rtl/pipelined_carry_chain_adder.sv
// pipelined_carry_chain_adder
// Carry-mux chain adder split into NSTAGE = ceil(WIDTH/STAGE_W) register
// stages. Stage k resolves bits [k*STAGE_W, min((k+1)*STAGE_W,WIDTH)-1] from
// the carry registered by stage k-1; bits not yet resolved travel forward in
// prop/gen skew registers and resolved sum bits travel forward with them so
// a whole transaction leaves the last stage together.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : pipelined_carry_chain_adder_if.slave (handshakes, operands, result)
// Parameters: WIDTH (4..64), STAGE_W (multiple of 4, <= WIDTH)
// Optional feature macro: CCA_COUT_EN adds the cout output and the final
// carry register feeding it.
module pipelined_carry_chain_adder #(
    parameter int WIDTH   = 22,
    parameter int STAGE_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    pipelined_carry_chain_adder_if.slave         io
);
    localparam int NSTAGE = (WIDTH + STAGE_W - 1) / STAGE_W;

    // The whole pipeline moves as one unit: it advances whenever the output
    // register is empty or being drained.
    logic advance;
    assign advance     = !io.out_valid || io.out_ready;
    assign io.in_ready = advance;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_st
        localparam int LO  = k * STAGE_W;
        localparam int HI  = ((k + 1) * STAGE_W < WIDTH) ? (k + 1) * STAGE_W : WIDTH;
        localparam int SW  = HI - LO;
        localparam int REM = WIDTH - HI;
`ifdef CCA_COUT_EN
        localparam bit KEEP_C = 1'b1;
`else
        // The last stage's carry only matters when cout is exported.
        localparam bit KEEP_C = (k < NSTAGE - 1);
`endif

        logic [SW-1:0] p_in;
        logic [SW-1:0] g_in;
        logic          c_in;
        logic          v_in;
        logic [SW-1:0] s_new;
        logic          c_run;
        logic [HI-1:0] s_cat;
        logic [HI-1:0] s_q;
        logic          v_q;

        always_comb begin
            c_run = c_in;
            s_new = '0;
            for (int i = 0; i < SW; i++) begin
                s_new[i] = p_in[i] ^ c_run;
                c_run    = p_in[i] ? c_run : g_in[i];
            end
        end

        if (k == 0) begin : g_src
            assign p_in  = io.prop[HI-1:0];
            assign g_in  = io.gen[HI-1:0];
            assign c_in  = io.cin;
            assign v_in  = io.in_valid;
            assign s_cat = s_new;
        end else begin : g_src
            assign p_in  = g_st[k-1].g_rest.p_q[SW-1:0];
            assign g_in  = g_st[k-1].g_rest.g_q[SW-1:0];
            assign c_in  = g_st[k-1].g_c.c_q;
            assign v_in  = g_st[k-1].v_q;
            assign s_cat = {s_new, g_st[k-1].s_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                s_q <= s_cat;
            end
        end

        if (KEEP_C) begin : g_c
            logic c_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_q <= 1'b0;
                end else if (advance) begin
                    c_q <= c_run;
                end
            end
        end

        // Skew registers for the bits later stages still have to resolve.
        if (REM > 0) begin : g_rest
            logic [REM-1:0] p_nx;
            logic [REM-1:0] g_nx;
            logic [REM-1:0] p_q;
            logic [REM-1:0] g_q;

            if (k == 0) begin : g_s0
                assign p_nx = io.prop[WIDTH-1:HI];
                assign g_nx = io.gen[WIDTH-1:HI];
            end else begin : g_sk
                assign p_nx = g_st[k-1].g_rest.p_q[WIDTH-LO-1:SW];
                assign g_nx = g_st[k-1].g_rest.g_q[WIDTH-LO-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q <= '0;
                    g_q <= '0;
                end else if (advance) begin
                    p_q <= p_nx;
                    g_q <= g_nx;
                end
            end
        end
    end

    assign io.product   = g_st[NSTAGE-1].s_q;
    assign io.out_valid = g_st[NSTAGE-1].v_q;
`ifdef CCA_COUT_EN
    assign io.cout      = g_st[NSTAGE-1].g_c.c_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// tb_pipelined_carry_chain_adder
// Random and directed stimulus against a reference that treats the carry-mux
// chain as an ordinary addition: with a = gen and b = prop ^ gen, the chain
// yields a + b + cin. Expected results are queued at acceptance and retired
// in order on each output handshake.
// Optional feature macro: CCA_COUT_EN (cout is then compared too).
module tb_pipelined_carry_chain_adder;
    localparam int WIDTH   = 22;
    localparam int STAGE_W = 8;
    localparam int NSTAGE  = (WIDTH + STAGE_W - 1) / STAGE_W;

    logic clk;
    logic rst_n;

    pipelined_carry_chain_adder_if #(.WIDTH(WIDTH)) io ();

    pipelined_carry_chain_adder #(
        .WIDTH   (WIDTH),
        .STAGE_W (STAGE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;
    int n_emit;
    logic [WIDTH:0] exp_q[$];

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] g,
                                               input logic c);
        logic [WIDTH:0] s;
        s = {1'b0, g} + {1'b0, p ^ g} + (WIDTH+1)'(c);
`ifndef CCA_COUT_EN
        s[WIDTH] = 1'b0;
`endif
        return s;
    endfunction

    function automatic logic [WIDTH:0] obs_word();
`ifdef CCA_COUT_EN
        return {io.cout, io.product};
`else
        return {1'b0, io.product};
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rnd_w();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    // Monitor: handshakes are evaluated at the falling edge, where inputs and
    // outputs are settled for the following rising edge.
    logic           prev_stall;
    logic [WIDTH:0] prev_word;
    initial begin
        prev_stall = 1'b0;
        prev_word  = '0;
    end

    always @(negedge rst_n) exp_q.delete();

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 65'(io.in_ready), 65'(!io.out_valid || io.out_ready));
            if (prev_stall) begin
                chk("hold_valid", 65'(io.out_valid), 65'(1));
                chk("hold_word", 65'(obs_word()), 65'(prev_word));
            end
            prev_stall = io.out_valid && !io.out_ready;
            prev_word  = obs_word();
            if (io.out_valid && io.out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 65'(1), 65'(0));
                end else begin
                    chk("out_word", 65'(obs_word()), 65'(exp_q.pop_front()));
                end
            end
            if (io.in_valid && io.in_ready)
                exp_q.push_back(ref_sum(io.prop, io.gen, io.cin));
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] p,
                         input logic [WIDTH-1:0] g, input logic c);
        @(posedge clk);
        #1;
        io.in_valid = v;
        io.prop     = p;
        io.gen      = g;
        io.cin      = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd_w(), rnd_w(), 1'($urandom_range(1)));
    endtask

    // One transaction into an empty pipeline; measures cycles to out_valid.
    task automatic lat_test(input string tag, input logic [WIDTH-1:0] p,
                            input logic [WIDTH-1:0] g, input logic c,
                            input logic [WIDTH:0] exp);
        int cnt;
        drive(1'b1, p, g, c);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        cnt = 1;
        while (!io.out_valid && cnt < 4 * NSTAGE + 4) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 65'(cnt), 65'(NSTAGE));
        chk({tag, "_word"}, 65'(obs_word()), 65'(exp));
    endtask

    task automatic wait_out_valid(input string tag);
        int cnt;
        cnt = 0;
        while (!io.out_valid && cnt < 4 * NSTAGE + 4) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_out_valid"}, 65'(io.out_valid), 65'(1));
    endtask

    logic [WIDTH-1:0] all1;
    logic [WIDTH:0]   top1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [WIDTH-1:0] a, b;
        n_chk = 0;
        n_err = 0;
        n_emit = 0;
        all1 = '1;
        top1 = '0;
`ifdef CCA_COUT_EN
        top1[WIDTH] = 1'b1;
`endif
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.prop      = '0;
        io.gen       = '0;
        io.cin       = 1'b0;
        io.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 65'(io.out_valid), 65'(0));
        chk("rst_product", 65'(obs_word()), 65'(0));
        chk("rst_in_ready", 65'(io.in_ready), 65'(1));
        #20;
        rst_n = 1'b1;
        idle(2);

        // Full-length carry ripple through every stage.
        lat_test("ripple", all1 & ~WIDTH'(1), all1, 1'b0, top1);
        idle(NSTAGE + 2);
        lat_test("prop_cin1", all1, '0, 1'b1, top1);
        idle(NSTAGE + 2);
        lat_test("prop_cin0", all1, '0, 1'b0, {1'b0, all1});
        idle(NSTAGE + 2);

        // Back-to-back random additions at full rate.
        e0 = n_emit;
        for (int i = 0; i < 1000; i++) begin
            a = rnd_w();
            b = rnd_w();
            drive(1'b1, a ^ b, a, 1'($urandom_range(1)));
        end
        idle(NSTAGE + 2);
        #2;
        chk("b2b_count", 65'(n_emit - e0), 65'(1000));
        chk("b2b_drained", 65'(exp_q.size()), 65'(0));

        // Random valid / ready traffic, junk operands on bubbles.
        for (int i = 0; i < 1500; i++) begin
            a = rnd_w();
            b = rnd_w();
            drive(1'($urandom_range(1)), a ^ b, a, 1'($urandom_range(1)));
            io.out_ready = ($urandom_range(3) != 0);
        end
        io.out_ready = 1'b1;
        idle(NSTAGE + 3);
        #2;
        chk("mix_drained", 65'(exp_q.size()), 65'(0));

        // Downstream stall with three transactions in flight.
        io.out_ready = 1'b0;
        e0 = n_emit;
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_w(), rnd_w(), 1'($urandom_range(1)));
        wait_out_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 65'(io.in_ready), 65'(0));
            chk("stall_word", 65'(obs_word()), 65'(exp_q[0]));
            @(posedge clk);
            #1;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        idle(NSTAGE + 3);
        #2;
        chk("stall_count", 65'(n_emit - e0), 65'(3));
        chk("stall_drained", 65'(exp_q.size()), 65'(0));

        // Reset pulse while two transactions are in flight.
        io.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) drive(1'b1, rnd_w(), rnd_w(), 1'($urandom_range(1)));
        drive(1'b0, '0, '0, 1'b0);
        wait_out_valid("rst_pre");
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 65'(io.out_valid), 65'(0));
        chk("rst_mid_product", 65'(obs_word()), 65'(0));
        chk("rst_mid_in_ready", 65'(io.in_ready), 65'(1));
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        a = rnd_w();
        b = rnd_w();
        lat_test("post_rst", a ^ b, a, 1'b1, ref_sum(a ^ b, a, 1'b1));
        idle(NSTAGE + 3);
        #2;
        chk("post_rst_drained", 65'(exp_q.size()), 65'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipelined_carry_chain_adder.md
PIPELINED_CARRY_CHAIN_ADDER -- requirements
Module: pipelined_carry_chain_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 22, giving the operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter STAGE_W, default 8, giving the bits resolved per pipeline stage: a multiple of 4, at most WIDTH.
REQ-003 The block SHALL derive NSTAGE = ceil(WIDTH/STAGE_W) as the pipeline depth; the last stage is narrower when WIDTH is not a multiple of STAGE_W.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  prop/gen/cin are valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 prop  input  WIDTH  per-bit propagate (carry-mux select).
REQ-009 gen  input  WIDTH  per-bit generate (carry-mux data when prop=0).
REQ-010 cin  input  1  carry into bit 0.
REQ-011 out_valid  output  1  product valid.
REQ-012 out_ready  input  1  downstream accepts product.
REQ-013 product  output  WIDTH  registered sum.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (present only with CCA_COUT_EN).

Function
REQ-015 Per bit i the block SHALL compute c[0]=cin, sum[i]=prop[i]^c[i], c[i+1]=prop[i]?c[i]:gen[i]; product=sum[WIDTH-1:0].
REQ-016 Stage k SHALL resolve bits [k*STAGE_W, min((k+1)*STAGE_W, WIDTH)-1] using the carry registered by stage k-1 (cin for stage 0).
REQ-017 The block SHALL delay unresolved prop/gen bits and already-resolved sum bits through skew registers so that all bits of one transaction emerge together.
REQ-018 Latency SHALL be exactly NSTAGE cycles from an accepted input (in_valid&&in_ready) to out_valid, absent stalls.
REQ-019 The block SHALL generate advance = !out_valid || out_ready; all stage registers, including each stage's valid bit, SHALL update only when advance=1.
REQ-020 in_ready SHALL equal advance (combinational from out_ready and out_valid only, never from in_valid).
REQ-021 An input SHALL be accepted when in_valid&&in_ready; with in_valid=0 a bubble (valid=0) SHALL enter stage 0.
REQ-022 While out_valid=1 and out_ready=0, product, cout and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-023 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-024 Transactions SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 The block SHALL ignore prop/gen/cin when in_valid=0.

Reset
REQ-026 When rst_n=0, all stage valid bits, out_valid, product and cout SHALL clear to 0 immediately, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight transaction; the first input accepted after release SHALL appear NSTAGE cycles later.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid=0.

Configuration
REQ-029 With macro CCA_COUT_EN defined, port cout SHALL exist and carry c[WIDTH] of the same transaction, aligned with product.
REQ-030 Without CCA_COUT_EN, port cout and its final-carry register SHALL be absent; product behaviour SHALL be unchanged.

Verification (WIDTH=22, STAGE_W=8, NSTAGE=3, CCA_COUT_EN defined)
REQ-031 prop=0x3FFFFE, gen=0x3FFFFF, cin=0, single valid at cycle 0, out_ready=1 -> out_valid at cycle 3, product=0x000000, cout=1.
REQ-032 prop=0x3FFFFF, gen=0, cin=1 -> product=0x000000, cout=1; with cin=0 -> product=0x3FFFFF, cout=0.
REQ-033 Back-to-back random prop=a^b, gen=a for 1000 cycles, out_ready=1 -> each product/cout equals (a+b+cin) mod 2^22 and bit 22, in order, one per cycle.
REQ-034 out_ready=0 for 5 cycles while 3 transactions are in flight -> in_ready=0 and product held stable; after out_ready=1, all 3 emerge in order without loss.
REQ-035 rst_n pulsed low for 1 cycle with 2 transactions in flight -> out_valid=0 immediately; no stale output appears; the next input appears 3 cycles after acceptance.
REQ-036 Rebuild with WIDTH=16, STAGE_W=4 and CCA_COUT_EN undefined -> latency 4, no cout port, REQ-033 check on product passes.
